// File: rtl/mem_port_scheduler_if.sv
// mem_port_scheduler_if: fetch/data request channels and the 16-bit memory pins of the port scheduler
interface mem_port_scheduler_if #(parameter int ADDR_WIDTH = 8);
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_gnt;
  logic                  instr_rvalid;
  logic [15:0]           instr_rdata;
  logic                  data_req;
  logic                  data_we;
  logic                  data_wide;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_gnt;
  logic                  data_rvalid;
  logic [31:0]           data_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic                  mem_enable;
  logic [15:0]           mem_rdata;
  modport master (
    output instr_req, instr_addr, data_req, data_we, data_wide, data_addr, data_wdata, mem_rdata,
    input  instr_gnt, instr_rvalid, instr_rdata, data_gnt, data_rvalid, data_rdata,
           mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_enable
  );
  modport slave (
    input  instr_req, instr_addr, data_req, data_we, data_wide, data_addr, data_wdata, mem_rdata,
    output instr_gnt, instr_rvalid, instr_rdata, data_gnt, data_rvalid, data_rdata,
           mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_enable
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: shares one 16-bit memory port between fetch and data; MEM_SCHED_FAIR_EN bounds data bursts
module mem_port_scheduler #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_port_scheduler_if.slave  bus,
  output logic                 busy_o
);
  typedef enum logic {IDLE, WIDE2} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wlo_q, hi_q;
  logic                  we_q, ipend, dpend, dwide;
  logic                  idle, w2, dgnt, ignt, fair_block;
  assign idle = state == IDLE && !rst_i;
  assign w2   = state == WIDE2 && !rst_i;
`ifdef MEM_SCHED_FAIR_EN
  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  logic [CW-1:0] cnt;
  assign fair_block = bus.instr_req && cnt >= CW'(MAX_DATA_BURST);
  always_ff @(posedge clk_i)
    if (rst_i || ignt) cnt <= '0;
    else if (dgnt && bus.instr_req) cnt <= cnt + 1'b1;
`else
  assign fair_block = MAX_DATA_BURST < 0;
`endif
  assign dgnt = idle && bus.data_req && !fair_block;
  assign ignt = idle && bus.instr_req && !dgnt;
  assign bus.data_gnt  = dgnt;
  assign bus.instr_gnt = ignt;
  // beat 0 comes straight from the winning request; beat 1 from the values latched at grant
  assign bus.mem_addr  = w2 ? addr_q : dgnt ? bus.data_addr : ignt ? bus.instr_addr : '0;
  assign bus.mem_wdata = w2 && we_q ? wlo_q :
                         dgnt && bus.data_we ? (bus.data_wide ? bus.data_wdata[31:16] : bus.data_wdata[15:0]) : '0;
  assign bus.mem_rd_en  = w2 ? !we_q : dgnt ? !bus.data_we : ignt;
  assign bus.mem_wr_en  = w2 ? we_q : dgnt && bus.data_we;
  assign bus.mem_enable = bus.mem_rd_en || bus.mem_wr_en;
  assign bus.instr_rvalid = ipend && !rst_i;
  assign bus.data_rvalid  = dpend && !rst_i;
  assign bus.instr_rdata  = bus.instr_rvalid ? bus.mem_rdata : '0;
  assign bus.data_rdata   = !bus.data_rvalid ? '0 : dwide ? {hi_q, bus.mem_rdata} : {16'h0, bus.mem_rdata};
  assign busy_o = !rst_i && (state != IDLE || ipend || dpend);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      ipend <= 1'b0;
      dpend <= 1'b0;
      dwide <= 1'b0;
    end else begin
      state <= dgnt && bus.data_wide ? WIDE2 : IDLE;
      ipend <= ignt;
      dpend <= (dgnt && !bus.data_we && !bus.data_wide) || (w2 && !we_q);
      dwide <= w2;
    end
  always_ff @(posedge clk_i) begin
    if (dgnt) begin
      addr_q <= bus.data_addr + 1'b1;
      wlo_q  <= bus.data_wdata[15:0];
      we_q   <= bus.data_we;
    end
    if (w2) hi_q <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed steps with a response scoreboard against a behavioural memory
module tb_mem_port_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;
  mem_port_scheduler_if #(.ADDR_WIDTH(8)) bus();
  mem_port_scheduler #(.ADDR_WIDTH(8), .MAX_DATA_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy)
  );
  logic [15:0] mem [256];
  logic [31:0] iq[$], dq[$];
  int passed = 0, total = 0;
  bit fair_on;
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return a == 8'h10 ? 16'hA5A5 : a == 8'h20 ? 16'h1234 : a == 8'h21 ? 16'h5678 : {a, ~a};
  endfunction
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.instr_rvalid) chk("instr_rdata", {16'h0, bus.instr_rdata}, iq.size() > 0 ? iq.pop_front() : 'x);
      if (bus.data_rvalid) chk("data_rdata", bus.data_rdata, dq.size() > 0 ? dq.pop_front() : 'x);
    end
  initial begin
`ifdef MEM_SCHED_FAIR_EN
    fair_on = 1'b1;
`else
    fair_on = 1'b0;
`endif
    bus.instr_req = 1'b1; bus.instr_addr = 8'h00;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_wide = 1'b0;
    bus.data_addr = 8'h00; bus.data_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_gnt", bus.data_gnt, 0);
    chk("rst_instr_gnt", bus.instr_gnt, 0);
    chk("rst_mem_enable", bus.mem_enable, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_rvalid", bus.data_rvalid, 0);
    step(); rst = 1'b0; bus.data_req = 1'b0; bus.instr_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_mem_enable", bus.mem_enable, 0);
    // narrow fetch
    step(); bus.instr_req = 1'b1; bus.instr_addr = 8'h10;
    @(negedge clk);
    chk("fetch_gnt", bus.instr_gnt, 1);
    chk("fetch_rd_en", bus.mem_rd_en, 1);
    chk("fetch_addr", bus.mem_addr, 32'h10);
    chk("fetch_data_gnt", bus.data_gnt, 0);
    iq.push_back(32'hA5A5);
    step(); bus.instr_req = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", bus.instr_rvalid, 1);
    // wide read
    step(); bus.data_req = 1'b1; bus.data_wide = 1'b1; bus.data_we = 1'b0; bus.data_addr = 8'h20;
    @(negedge clk);
    chk("wrd_gnt", bus.data_gnt, 1);
    chk("wrd_addr0", bus.mem_addr, 32'h20);
    chk("wrd_rd0", bus.mem_rd_en, 1);
    dq.push_back(32'h12345678);
    step(); bus.data_req = 1'b0;
    @(negedge clk);
    chk("wrd_no_gnt", bus.data_gnt, 0);
    chk("wrd_addr1", bus.mem_addr, 32'h21);
    chk("wrd_rd1", bus.mem_rd_en, 1);
    chk("wrd_busy", busy, 1);
    chk("wrd_early_rvalid", bus.data_rvalid, 0);
    step();
    @(negedge clk);
    chk("wrd_rvalid", bus.data_rvalid, 1);
    chk("wrd_port_idle", bus.mem_enable, 0);
    // wide write with fetch waiting
    step(); bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_wide = 1'b1;
    bus.data_addr = 8'hFF; bus.data_wdata = 32'hDEADBEEF;
    bus.instr_req = 1'b1; bus.instr_addr = 8'h30;
    @(negedge clk);
    chk("wwr_gnt", bus.data_gnt, 1);
    chk("wwr_instr_blocked", bus.instr_gnt, 0);
    chk("wwr_addr0", bus.mem_addr, 32'hFF);
    chk("wwr_wdata0", bus.mem_wdata, 32'hDEAD);
    chk("wwr_wr0", bus.mem_wr_en, 1);
    chk("wwr_rd0", bus.mem_rd_en, 0);
    step(); bus.data_req = 1'b0;
    @(negedge clk);
    chk("wwr_instr_wide2", bus.instr_gnt, 0);
    chk("wwr_addr1", bus.mem_addr, 32'h00);
    chk("wwr_wdata1", bus.mem_wdata, 32'hBEEF);
    chk("wwr_wr1", bus.mem_wr_en, 1);
    step();
    @(negedge clk);
    chk("wwr_fetch_after", bus.instr_gnt, 1);
    chk("wwr_fetch_addr", bus.mem_addr, 32'h30);
    chk("wwr_no_rvalid", bus.data_rvalid, 0);
    iq.push_back({16'h0, init_val(8'h30)});
    step(); bus.instr_req = 1'b0;
    @(negedge clk);
    chk("wwr_mem_hi", mem[8'hFF], 32'hDEAD);
    chk("wwr_mem_lo", mem[8'h00], 32'hBEEF);
    // simultaneous narrow requests
    step(); bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_wide = 1'b0; bus.data_addr = 8'h40;
    bus.instr_req = 1'b1; bus.instr_addr = 8'h41;
    @(negedge clk);
    chk("sim_data_gnt", bus.data_gnt, 1);
    chk("sim_instr_wait", bus.instr_gnt, 0);
    dq.push_back({16'h0, init_val(8'h40)});
    step(); bus.data_req = 1'b0;
    @(negedge clk);
    chk("sim_instr_gnt", bus.instr_gnt, 1);
    chk("sim_resp_overlap", bus.data_rvalid, 1);
    iq.push_back({16'h0, init_val(8'h41)});
    step(); bus.instr_req = 1'b0;
    @(negedge clk);
    // reset during WIDE2
    step(); bus.data_req = 1'b1; bus.data_wide = 1'b1; bus.data_addr = 8'h50;
    @(negedge clk);
    chk("rw2_gnt", bus.data_gnt, 1);
    step(); bus.data_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rw2_port_off", bus.mem_enable, 0);
    chk("rw2_busy_off", busy, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rw2_no_rvalid", bus.data_rvalid, 0);
    chk("rw2_idle_busy", busy, 0);
    chk("rw2_idle_port", bus.mem_enable, 0);
    // sustained contention
    step(); bus.data_req = 1'b1; bus.data_wide = 1'b0; bus.data_we = 1'b0; bus.data_addr = 8'h60;
    bus.instr_req = 1'b1; bus.instr_addr = 8'h61;
    for (int c = 0; c < 10; c++) begin
      logic exp_i;
      if (c > 0) step();
      exp_i = fair_on && (c % 5 == 4);
      @(negedge clk);
      chk($sformatf("arb%0d_instr", c), bus.instr_gnt, exp_i);
      chk($sformatf("arb%0d_data", c), bus.data_gnt, !exp_i);
      if (exp_i) iq.push_back({16'h0, init_val(8'h61)});
      else dq.push_back({16'h0, init_val(8'h60)});
    end
    step(); bus.data_req = 1'b0; bus.instr_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("instr_q_drained", iq.size(), 0);
    chk("data_q_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
